// File: rtl/vga_pattern_sequencer.sv
// vga_pattern_sequencer: frame-aligned scheduler choosing which pattern source drives the VGA rgb pins
module vga_pattern_sequencer #(
  parameter int N_PAT          = 4,
  parameter int FRAMES_PER_PAT = 120,
  parameter int DEBOUNCE_CYC   = 250000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               de,
  input  logic [9:0]         sx,
  input  logic [9:0]         sy,
  input  logic               btn_next,
  input  logic               btn_mode,
  input  logic [N_PAT*6-1:0] rgb_in,
  output logic [5:0]         rgb,
  output logic [1:0]         pat_sel,
  output logic               auto_mode,
  output logic               frame_tick
);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DW-1:0] LIM = DW'(DEBOUNCE_CYC - 1);
  typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} state_e;
  state_e          state_q, state_d;
  logic [1:0]      nsync_q, msync_q;
  logic            ndb_q, ndb_d, mdb_q, mdb_d;
  logic [DW-1:0]   ncnt_q, ncnt_d, mcnt_q, mcnt_d;
  logic [7:0]      fcnt_q, fcnt_d;
  logic            pend_q, pend_d;
  logic [1:0]      pat_sel_q, pat_sel_d;
  logic [5:0]      rgb_q, rgb_d;
  logic            tick_q, tick_d;
  logic            nev, mev, bnd, expire, adv;
  assign rgb        = rgb_q;
  assign pat_sel    = pat_sel_q;
  assign auto_mode  = (state_q == AUTO);
  assign frame_tick = tick_q;
  // Debounce, press detection, mode/advance scheduling and the output mux for the next cycle.
  always_comb begin
    nev       = nsync_q[1] & ~ndb_q & (ncnt_q == LIM);
    mev       = msync_q[1] & ~mdb_q & (mcnt_q == LIM);
    ndb_d     = (nsync_q[1] != ndb_q && ncnt_q == LIM) ? nsync_q[1] : ndb_q;
    mdb_d     = (msync_q[1] != mdb_q && mcnt_q == LIM) ? msync_q[1] : mdb_q;
    ncnt_d    = (nsync_q[1] == ndb_q) ? '0 : (ncnt_q == LIM) ? ncnt_q : ncnt_q + 1'b1;
    mcnt_d    = (msync_q[1] == mdb_q) ? '0 : (mcnt_q == LIM) ? mcnt_q : mcnt_q + 1'b1;
    bnd       = (sx == 10'd0) && (sy == 10'd0);
    expire    = (state_q == AUTO) && (fcnt_q == 8'(FRAMES_PER_PAT - 1));
    adv       = bnd && (pend_q || expire);
    pat_sel_d = adv ? ((pat_sel_q == 2'(N_PAT - 1)) ? 2'd0 : pat_sel_q + 2'd1) : pat_sel_q;
    pend_d    = nev | (pend_q & ~adv);
    state_d   = mev ? state_e'(~state_q) : state_q;
    fcnt_d    = (mev || state_q != AUTO || (bnd && expire)) ? 8'd0 : bnd ? fcnt_q + 8'd1 : fcnt_q;
    rgb_d     = de ? rgb_in[6*pat_sel_d +: 6] : 6'd0;
    tick_d    = bnd;
  end
  // State registers; reset asserts asynchronously and returns to source 0 in AUTO with nothing pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= AUTO;
      nsync_q   <= '0;
      msync_q   <= '0;
      ndb_q     <= 1'b0;
      mdb_q     <= 1'b0;
      ncnt_q    <= '0;
      mcnt_q    <= '0;
      fcnt_q    <= '0;
      pend_q    <= 1'b0;
      pat_sel_q <= '0;
      rgb_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      nsync_q   <= {nsync_q[0], btn_next};
      msync_q   <= {msync_q[0], btn_mode};
      ndb_q     <= ndb_d;
      mdb_q     <= mdb_d;
      ncnt_q    <= ncnt_d;
      mcnt_q    <= mcnt_d;
      fcnt_q    <= fcnt_d;
      pend_q    <= pend_d;
      pat_sel_q <= pat_sel_d;
      rgb_q     <= rgb_d;
      tick_q    <= tick_d;
    end
  end
endmodule
